// File: rtl/cntlr_poll_sched.sv
// cntlr_poll_sched: periodic poll scheduler for one N64 joybus controller port.
// Launches CMD_POLL on the TX serializer, arms the RX deserializer one cycle
// after TX completes and latches the returned 32-bit word. Per-phase timeout,
// bounded retry, link status and a saturating error counter are included.
// Optional build macro: CNTLR_ZERO_ON_FAIL_EN -- a failed slot clears btn_data
// to the neutral pad value and pulses btn_valid once.
module cntlr_poll_sched #(
    parameter int unsigned POLL_PERIOD  = 416667,
    parameter int unsigned RESP_TIMEOUT = 5000,
    parameter int unsigned MAX_RETRY    = 2,
    parameter logic [7:0]  CMD_POLL     = 8'h01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        poll_now,
    output logic        tx_start,
    output logic [7:0]  tx_cmd,
    input  logic        tx_done,
    output logic        rx_start,
    input  logic        rx_done,
    input  logic [31:0] rx_data,
    output logic [31:0] btn_data,
    output logic        btn_valid,
    output logic        link_ok,
    output logic [7:0]  err_cnt,
    output logic        busy
);

    localparam int unsigned   PW           = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int unsigned   TW           = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [PW-1:0] PERIOD_LAST  = PW'(POLL_PERIOD - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(RESP_TIMEOUT - 1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_TX,
        ST_ARM,
        ST_WAIT_RX,
        ST_FAIL
    } state_t;

    state_t        state_q,      state_d;
    logic [PW-1:0] period_cnt_q, period_cnt_d;
    logic          pending_q,    pending_d;
    logic [3:0]    retry_q,      retry_d;
    logic [TW-1:0] tmo_q,        tmo_d;
    logic [7:0]    err_q,        err_d;
    logic          link_q,       link_d;
    logic [31:0]   btn_data_q,   btn_data_d;
    logic          btn_valid_q,  btn_valid_d;
    logic          tx_start_q,   tx_start_d;
    logic          rx_start_q,   rx_start_d;
    logic          period_wrap;

    // Period counter: runs while enabled, wraps at POLL_PERIOD-1 and flags a poll.
    always_comb begin
        period_cnt_d = period_cnt_q;
        period_wrap  = 1'b0;
        if (!en) begin
            period_cnt_d = '0;
        end else if (period_cnt_q == PERIOD_LAST) begin
            period_cnt_d = '0;
            period_wrap  = 1'b1;
        end else begin
            period_cnt_d = period_cnt_q + 1'b1;
        end
    end

    // Poll request latch: requests collapse into one; consumed when the FSM leaves IDLE.
    // A request in the very cycle the FSM launches is served by that launch.
    always_comb begin
        pending_d = pending_q | period_wrap | poll_now;
        if ((state_q == ST_IDLE) && pending_q) begin
            pending_d = 1'b0;
        end
    end

    // Slot sequencing: next state, timeout/retry counters, status and result capture.
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        retry_d     = retry_q;
        err_d       = err_q;
        link_d      = link_q;
        btn_data_d  = btn_data_q;
        btn_valid_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                tmo_d   = '0;
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (tx_done) begin
                    state_d = ST_ARM;
                end else if (tmo_q == TIMEOUT_LAST) begin
                    state_d = ST_FAIL;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_ARM: begin
                tmo_d   = '0;
                state_d = ST_WAIT_RX;
            end
            ST_WAIT_RX: begin
                if (rx_done) begin
                    btn_data_d  = rx_data;
                    btn_valid_d = 1'b1;
                    link_d      = 1'b1;
                    retry_d     = '0;
                    state_d     = ST_IDLE;
                end else if (tmo_q == TIMEOUT_LAST) begin
                    state_d = ST_FAIL;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_FAIL: begin
                if (err_q != 8'hFF) begin
                    err_d = err_q + 8'd1;
                end
                if (retry_q < RETRY_LIMIT) begin
                    retry_d = retry_q + 4'd1;
                    state_d = ST_LAUNCH;
                end else begin
                    link_d  = 1'b0;
                    retry_d = '0;
                    state_d = ST_IDLE;
`ifdef CNTLR_ZERO_ON_FAIL_EN
                    btn_data_d  = '0;
                    btn_valid_d = 1'b1;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Strobes decode the next state so they are high during LAUNCH/ARM themselves.
        tx_start_d = (state_d == ST_LAUNCH);
        rx_start_d = (state_d == ST_ARM);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            period_cnt_q <= '0;
            pending_q    <= 1'b0;
            retry_q      <= '0;
            tmo_q        <= '0;
            err_q        <= '0;
            link_q       <= 1'b0;
            btn_data_q   <= '0;
            btn_valid_q  <= 1'b0;
            tx_start_q   <= 1'b0;
            rx_start_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            pending_q    <= pending_d;
            retry_q      <= retry_d;
            tmo_q        <= tmo_d;
            err_q        <= err_d;
            link_q       <= link_d;
            btn_data_q   <= btn_data_d;
            btn_valid_q  <= btn_valid_d;
            tx_start_q   <= tx_start_d;
            rx_start_q   <= rx_start_d;
        end
    end

    assign tx_start  = tx_start_q;
    assign tx_cmd    = CMD_POLL;
    assign rx_start  = rx_start_q;
    assign btn_data  = btn_data_q;
    assign btn_valid = btn_valid_q;
    assign link_ok   = link_q;
    assign err_cnt   = err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cntlr_poll_sched.sv
// tb_cntlr_poll_sched: randomized bench for cntlr_poll_sched. The bench plays
// the joybus TX/RX pair; for each slot it derives the cycle of every expected
// tx_start / rx_start / btn_valid pulse from the timing rules and queues them,
// and a negedge monitor pops and compares as the DUT emits pulses.
module tb_cntlr_poll_sched;

    localparam int         P   = 1000;
    localparam int         T   = 64;
    localparam int         MR  = 2;
    localparam logic [7:0] CMD = 8'h01;

    localparam int K_TX  = 0;
    localparam int K_RX  = 1;
    localparam int K_BTN = 2;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        en       = 1'b0;
    logic        poll_now = 1'b0;
    logic        tx_done  = 1'b0;
    logic        rx_done  = 1'b0;
    logic [31:0] rx_data  = '0;
    logic        tx_start;
    logic [7:0]  tx_cmd;
    logic        rx_start;
    logic [31:0] btn_data;
    logic        btn_valid;
    logic        link_ok;
    logic [7:0]  err_cnt;
    logic        busy;

    cntlr_poll_sched #(
        .POLL_PERIOD (P),
        .RESP_TIMEOUT(T),
        .MAX_RETRY   (MR),
        .CMD_POLL    (CMD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .poll_now (poll_now),
        .tx_start (tx_start),
        .tx_cmd   (tx_cmd),
        .tx_done  (tx_done),
        .rx_start (rx_start),
        .rx_done  (rx_done),
        .rx_data  (rx_data),
        .btn_data (btn_data),
        .btn_valid(btn_valid),
        .link_ok  (link_ok),
        .err_cnt  (err_cnt),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        int          at;
        logic [31:0] data;
        logic        link;
        logic [7:0]  err;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Reference model of the visible status
    int          m_err  = 0;
    logic        m_link = 1'b0;
    logic [31:0] m_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int k, input int at, input logic [31:0] d, input logic l, input int e);
        ev_t ev;
        ev.kind = k;
        ev.at   = at;
        ev.data = d;
        ev.link = l;
        ev.err  = 8'(e);
        exp_q.push_back(ev);
    endtask

    task automatic mon_take(input int k);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse: got pulse kind %0d at cycle %0d, required none", k, cyc);
        end else begin
            e = exp_q.pop_front();
            check("pulse_kind", 64'(k), 64'(e.kind));
            check("pulse_cycle", 64'(cyc), 64'(e.at));
            if (k == K_TX) check("tx_cmd", 64'(tx_cmd), 64'(CMD));
            if (k == K_BTN) begin
                check("btn_data", 64'(btn_data), 64'(e.data));
                check("btn_link_ok", 64'(link_ok), 64'(e.link));
                check("btn_err_cnt", 64'(err_cnt), 64'(e.err));
            end
        end
    endtask

    // Monitor: every output pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (tx_start)  mon_take(K_TX);
        if (rx_start)  mon_take(K_RX);
        if (btn_valid) mon_take(K_BTN);
    end

    task automatic wait_until(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_poll(input int n);
        wait_until(n);
        poll_now = 1'b1;
        wait_until(n + 1);
        poll_now = 1'b0;
    endtask

    task automatic pulse_tx(input int n);
        wait_until(n);
        tx_done = 1'b1;
        wait_until(n + 1);
        tx_done = 1'b0;
    endtask

    task automatic pulse_rx(input int n, input logic [31:0] d);
        wait_until(n);
        rx_done = 1'b1;
        rx_data = d;
        wait_until(n + 1);
        rx_done = 1'b0;
        rx_data = $urandom;
    endtask

    task automatic bump_err();
        if (m_err < 255) m_err++;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx_start"},  64'(tx_start),  64'd0);
        check({tag, "_rx_start"},  64'(rx_start),  64'd0);
        check({tag, "_btn_valid"}, 64'(btn_valid), 64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_btn_data"},  64'(btn_data),  64'd0);
        check({tag, "_link_ok"},   64'(link_ok),   64'd0);
        check({tag, "_err_cnt"},   64'(err_cnt),   64'd0);
        check({tag, "_tx_cmd"},    64'(tx_cmd),    64'(CMD));
    endtask

    // One poll slot. Request seen in cycle c (poll_now pulse, or a pending
    // request from elsewhere) -> tx_start at c+2. n_fail failed attempts precede
    // the successful one; n_fail > MR means the whole slot fails.
    task automatic run_slot(input bit use_poll, input int c, input int n_fail,
                            input logic [31:0] data, input bit boundary,
                            input bit extra_req, input int tx_fix, output int end_cyc);
        int L, d, r, k, attempts;
        bit ok;
        L        = c + 2;
        end_cyc  = L;
        attempts = (n_fail > MR) ? MR + 1 : n_fail + 1;
        for (int a = 0; a < attempts; a++) begin
            ok = (a == n_fail);
            push(K_TX, L, 32'(CMD), 1'b0, 0);
            if (a == 0) begin
                if (use_poll)  pulse_poll(c);
                if (extra_req) pulse_poll(c + 2);
            end
            if (!ok && ($urandom_range(0, 1) == 0)) begin
                // TX never completes; a stray rx_done during WAIT_TX must be ignored
                pulse_rx(L + 1, $urandom);
                bump_err();
                L = L + T + 2;
            end else begin
                k = (tx_fix != 0) ? tx_fix : int'($urandom_range(1, T));
                d = L + k;
                push(K_RX, d + 1, '0, 1'b0, 0);
                pulse_tx(d);
                if (ok) begin
                    r      = boundary ? d + T + 1 : d + int'($urandom_range(2, T + 1));
                    m_link = 1'b1;
                    m_data = data;
                    push(K_BTN, r + 1, data, 1'b1, m_err);
                    pulse_rx(r, data);
                    end_cyc = r + 1;
                end else begin
                    // RX never answers; a stray tx_done during WAIT_RX must be ignored
                    pulse_tx(d + 3);
                    bump_err();
                    L = d + T + 3;
                end
            end
        end
        if (n_fail > MR) begin
            m_link  = 1'b0;
            end_cyc = L;
`ifdef CNTLR_ZERO_ON_FAIL_EN
            m_data = '0;
            push(K_BTN, L, '0, 1'b0, m_err);
`endif
        end
        wait_until(end_cyc);
        check("slot_end_busy",     64'(busy),     64'd0);
        check("slot_end_link_ok",  64'(link_ok),  64'(m_link));
        check("slot_end_err_cnt",  64'(err_cnt),  64'(m_err));
        check("slot_end_btn_data", 64'(btn_data), 64'(m_data));
    endtask

    // Stimulus
    initial begin
        int e, e0, c, L, d;
        rx_data = $urandom;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        wait_until(3);
        check_reset_vals("reset");
        rst_n = 1'b1;
        wait_until(cyc + 3);

        // Normal poll, retry success, dead controller, rx_done at the timeout boundary
        run_slot(1'b1, cyc + 2, 0, 32'h8000_1234, 1'b0, 1'b0, 0, e);
        run_slot(1'b1, cyc + 1, 1, 32'hFFFF_0000, 1'b0, 1'b0, 0, e);
        run_slot(1'b1, cyc + 1, 3, $urandom, 1'b0, 1'b0, 0, e);
        run_slot(1'b1, cyc + 1, 0, 32'h1357_9BDF, 1'b1, 1'b0, 0, e);

        // Periodic launches exactly P cycles apart
        en = 1'b1;
        e0 = cyc;
        run_slot(1'b0, e0 + P - 1, 0, $urandom, 1'b0, 1'b0, 0, e);
        run_slot(1'b0, e0 + 2 * P - 1, 0, $urandom, 1'b0, 1'b0, 0, e);
        en = 1'b0;
        wait_until(cyc + 5);

        // poll_now while busy plus a period wrap in the same slot -> one extra slot
        en = 1'b1;
        e0 = cyc;
        run_slot(1'b1, e0 + P - 50, 0, $urandom, 1'b0, 1'b1, 60, e);
        en = 1'b0;
        run_slot(1'b0, e - 1, 0, $urandom, 1'b0, 1'b0, 0, e);
        wait_until(cyc + 200);

        // Randomized mix
        for (int i = 0; i < 16; i++) begin
            run_slot(1'b1, cyc + int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                     $urandom, ($urandom_range(0, 3) == 0), 1'b0, 0, e);
        end

        // Error counter saturation
        while (m_err < 255) run_slot(1'b1, cyc, 3, $urandom, 1'b0, 1'b0, 0, e);
        run_slot(1'b1, cyc, 3, $urandom, 1'b0, 1'b0, 0, e);
        run_slot(1'b1, cyc + 1, 3, $urandom, 1'b0, 1'b0, 0, e);

        // Reset during WAIT_RX, then a late rx_done
        c = cyc + 1;
        L = c + 2;
        push(K_TX, L, 32'(CMD), 1'b0, 0);
        pulse_poll(c);
        d = L + 5;
        push(K_RX, d + 1, '0, 1'b0, 0);
        pulse_tx(d);
        wait_until(d + 4);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        m_err  = 0;
        m_link = 1'b0;
        m_data = '0;
        wait_until(cyc + 3);
        rst_n = 1'b1;
        pulse_rx(cyc + 2, 32'hDEAD_BEEF);
        wait_until(cyc + 20);
        check("late_rx_btn_data", 64'(btn_data), 64'd0);
        check("late_rx_link_ok",  64'(link_ok),  64'd0);
        check("late_rx_busy",     64'(busy),     64'd0);

        wait_until(cyc + 10);
        check("expect_queue_left", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Bound on total run time
    initial begin
        #3000000;
        n_bad++;
        $display("FAIL watchdog: got no completion by cycle %0d, required completion", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
